// File: rtl/tone_arbiter.sv
// Shares one tone generator among N requesters: round-robin grant, enable/over
// handshake with the generator, silent gap between notes, requester-0 preemption.
module tone_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned OCT_W      = 3,
    parameter int unsigned NOTE_W     = 3,
    parameter int unsigned LEN_W      = 3,
    parameter int unsigned GAP_CYCLES = 5000000,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned PREEMPT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    input  logic [N*OCT_W-1:0]    req_oct,
    input  logic [N*NOTE_W-1:0]   req_note,
    input  logic [N*LEN_W-1:0]    req_len,
    input  logic                  cancel,
    input  logic                  sound_over,
    output logic                  sound_en,
    output logic [OCT_W-1:0]      sound_oct,
    output logic [NOTE_W-1:0]     sound_note,
    output logic [LEN_W-1:0]      sound_len,
    output logic [N-1:0]          gnt,
    output logic [N-1:0]          done,
    output logic [N-1:0]          abort,
    output logic                  busy
);

    localparam int unsigned PTR_W    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_MAX  = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
    localparam int unsigned CNT_W    = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam int unsigned TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_GAP} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                pre_pend_q, pre_pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sound_en_q, sound_en_d;
    logic [OCT_W-1:0]    oct_q, oct_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [N-1:0]        done_q, done_d;
    logic [N-1:0]        abort_q, abort_d;
    logic                busy_q, busy_d;

    logic [PTR_W-1:0]    rr_win_c;
    logic [PTR_W-1:0]    win_c;
    logic                take_c;
    logic                preempt_c;
    logic                kill_c;
    logic [N-1:0]        cur_oh_c;

    // Round-robin scan from ptr+1; descending loop lets the nearest requester win.
    always_comb begin : arb
        logic [PTR_W-1:0] idx;
        idx      = '0;
        rr_win_c = '0;
        for (int i = int'(N); i >= 1; i--) begin
            idx = PTR_W'((int'(ptr_q) + i) % int'(N));
            if (req[idx]) rr_win_c = idx;
        end
        take_c = |req;
        win_c  = (pre_pend_q && req[0]) ? '0 : rr_win_c;
    end

    assign cur_oh_c  = N'(1) << ptr_q;
    assign preempt_c = (PREEMPT != 0) && req[0] && (ptr_q != '0);
    assign kill_c    = cancel || preempt_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pre_pend_d = pre_pend_q;
        cnt_d      = '0;
        sound_en_d = sound_en_q;
        oct_d      = oct_q;
        note_d     = note_q;
        len_d      = len_q;
        gnt_d      = '0;
        done_d     = '0;
        abort_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                sound_en_d = 1'b0;
                if (take_c) begin
                    oct_d      = req_oct[int'(win_c)*OCT_W +: OCT_W];
                    note_d     = req_note[int'(win_c)*NOTE_W +: NOTE_W];
                    len_d      = req_len[int'(win_c)*LEN_W +: LEN_W];
                    gnt_d      = N'(1) << win_c;
                    ptr_d      = win_c;
                    pre_pend_d = 1'b0;
                    sound_en_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (kill_c) begin
                    abort_d    = cur_oh_c;
                    sound_en_d = 1'b0;
                    state_d    = S_GAP;
                    if (preempt_c) pre_pend_d = 1'b1;
                end else if (!sound_over) begin
                    state_d = S_PLAY;
                end else if (cnt_q >= CNT_W'(TO_LAST)) begin
                    abort_d    = cur_oh_c;
                    sound_en_d = 1'b0;
                    state_d    = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PLAY: begin
                // Completion outranks a same-cycle cancel or preempt.
                if (sound_over) begin
                    done_d     = cur_oh_c;
                    sound_en_d = 1'b0;
                    state_d    = S_GAP;
                end else if (kill_c) begin
                    abort_d    = cur_oh_c;
                    sound_en_d = 1'b0;
                    state_d    = S_GAP;
                    if (preempt_c) pre_pend_d = 1'b1;
                end
            end
            S_GAP: begin
                sound_en_d = 1'b0;
                if (cnt_q >= CNT_W'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                sound_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= PTR_W'(N - 1);
            pre_pend_q <= 1'b0;
            cnt_q      <= '0;
            sound_en_q <= 1'b0;
            oct_q      <= '0;
            note_q     <= '0;
            len_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            abort_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pre_pend_q <= pre_pend_d;
            cnt_q      <= cnt_d;
            sound_en_q <= sound_en_d;
            oct_q      <= oct_d;
            note_q     <= note_d;
            len_q      <= len_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
        end
    end

    assign sound_en   = sound_en_q;
    assign sound_oct  = oct_q;
    assign sound_note = note_q;
    assign sound_len  = len_q;
    assign gnt        = gnt_q;
    assign done       = done_q;
    assign abort      = abort_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Scoreboard bench for tone_arbiter: directed note scenarios push expected
// gnt/done/abort pulses; a negedge monitor pops and compares them.
module tb_tone_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned OW = 3;
    localparam int unsigned NW = 3;
    localparam int unsigned LW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*OW-1:0] req_oct;
    logic [N*NW-1:0] req_note;
    logic [N*LW-1:0] req_len;
    logic            cancel;
    logic            sound_over;
    logic            sound_en;
    logic [OW-1:0]   sound_oct;
    logic [NW-1:0]   sound_note;
    logic [LW-1:0]   sound_len;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [N-1:0]    abort;
    logic            busy;

    tone_arbiter #(
        .N(N), .OCT_W(OW), .NOTE_W(NW), .LEN_W(LW),
        .GAP_CYCLES(10), .TIMEOUT(8), .PREEMPT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_oct(req_oct),
        .req_note(req_note), .req_len(req_len), .cancel(cancel),
        .sound_over(sound_over), .sound_en(sound_en), .sound_oct(sound_oct),
        .sound_note(sound_note), .sound_len(sound_len), .gnt(gnt),
        .done(done), .abort(abort), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;   // 0 gnt, 1 done, 2 abort
        logic [N-1:0] vec;
        logic [2:0]   oct;
        logic [2:0]   note;
        logic [2:0]   len;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Requester i presents octave i+3, note i+2, length i+3.
    function automatic logic [2:0] ex_oct(int i);  return 3'(i + 3); endfunction
    function automatic logic [2:0] ex_note(int i); return 3'(i + 2); endfunction
    function automatic logic [2:0] ex_len(int i);  return 3'(i + 3); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int idx);
        exp_t e;
        e.kind = kind;
        e.vec  = N'(1) << idx;
        e.oct  = ex_oct(idx);
        e.note = ex_note(idx);
        e.len  = ex_len(idx);
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int max);
        int n = 0;
        while (!sound_en && n < max) begin
            step();
            n++;
        end
        chk("wait_sound_en", 32'(sound_en), 1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk("wait_idle", 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req        = '0;
        cancel     = 1'b0;
        sound_over = 1'b1;
        #7;
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t         e;
        int           k;
        logic [N-1:0] v;
        if (rst_n && (gnt | done | abort) != '0) begin
            k = (gnt != '0) ? 0 : (done != '0) ? 1 : 2;
            v = gnt | done | abort;
            chk("pulse_exclusive", $countones({gnt != '0, done != '0, abort != '0}), 1);
            chk("pulse_onehot", $countones(v), 1);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse kind=%0d vec=%b", k, v);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", k, e.kind);
                chk("pulse_vec", 32'(v), 32'(e.vec));
                if (e.kind == 0) begin
                    chk("gnt_oct", 32'(sound_oct), 32'(e.oct));
                    chk("gnt_note", 32'(sound_note), 32'(e.note));
                    chk("gnt_len", 32'(sound_len), 32'(e.len));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int cnt;
        for (int i = 0; i < int'(N); i++) begin
            req_oct[i*OW +: OW]  = ex_oct(i);
            req_note[i*NW +: NW] = ex_note(i);
            req_len[i*LW +: LW]  = ex_len(i);
        end
        rst_n      = 1'b0;
        req        = '0;
        cancel     = 1'b0;
        sound_over = 1'b1;
        #23;
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_sound_en", 32'(sound_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fields", 32'({sound_oct, sound_note, sound_len}), 0);
        chk("rst_pulses", 32'({gnt, done, abort}), 0);

        // Single note for requester 1, then the 10-cycle gap
        push(0, 1);
        req = 4'b0010;
        step();
        chk("single_en_at_gnt", 32'(sound_en), 1);
        chk("single_busy", 32'(busy), 1);
        req = '0;
        sound_over = 1'b0;
        repeat (3) step();
        chk("single_en_play", 32'(sound_en), 1);
        push(1, 1);
        sound_over = 1'b1;
        step();
        chk("single_en_off", 32'(sound_en), 0);
        chk("single_oct_stable", 32'(sound_oct), 4);
        repeat (9) step();
        chk("gap_still_busy", 32'(busy), 1);
        step();
        chk("gap_end_idle", 32'(busy), 0);

        // Cancel in IDLE does nothing
        cancel = 1'b1;
        repeat (2) step();
        cancel = 1'b0;
        chk("cancel_idle_ignored", 32'(busy), 0);

        // Round robin: 1..3 keep re-requesting, 0 re-requests during the last gap
        do_reset();
        push(0, 0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_en(40);
            if (k == 4) req = '0;
            else if (k == 0) req[0] = 1'b0;
            sound_over = 1'b0;
            repeat (18) step();
            push(1, k % 4);
            sound_over = 1'b1;
            step();
            if (k == 3) req[0] = 1'b1;
            if (k < 4) push(0, (k + 1) % 4);
        end
        wait_idle(40);

        // Preemption of requester 2 by requester 0, with 3 also waiting
        do_reset();
        push(0, 2);
        req = 4'b0100;
        wait_en(5);
        req = '0;
        sound_over = 1'b0;
        repeat (2) step();
        push(2, 2);
        req = 4'b1001;
        step();
        chk("preempt_en_drop", 32'(sound_en), 0);
        sound_over = 1'b1;
        push(0, 0);
        wait_en(30);
        req = 4'b1000;
        sound_over = 1'b0;
        repeat (3) step();
        push(1, 0);
        sound_over = 1'b1;
        step();
        // Requester 3 next; cancel it while still in START
        push(0, 3);
        wait_en(30);
        req = '0;
        step();
        push(2, 3);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_start_en", 32'(sound_en), 0);
        wait_idle(30);

        // Cancel and completion on the same edge: done only
        do_reset();
        push(0, 0);
        req = 4'b0001;
        wait_en(5);
        req = '0;
        sound_over = 1'b0;
        repeat (3) step();
        push(1, 0);
        cancel = 1'b1;
        sound_over = 1'b1;
        step();
        cancel = 1'b0;
        chk("tie_en_off", 32'(sound_en), 0);
        wait_idle(30);

        // Timeout: generator never accepts
        do_reset();
        push(0, 2);
        push(2, 2);
        req = 4'b0100;
        wait_en(5);
        req = '0;
        cnt = 0;
        while (sound_en && cnt < 50) begin
            cnt++;
            step();
        end
        chk("timeout_en_cycles", cnt, 8);
        chk("timeout_busy_gap", 32'(busy), 1);
        wait_idle(30);

        // Asynchronous reset mid-PLAY
        do_reset();
        push(0, 1);
        req = 4'b0010;
        wait_en(5);
        req = '0;
        sound_over = 1'b0;
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sound_en", 32'(sound_en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pulses", 32'({gnt, done, abort}), 0);
        sound_over = 1'b1;
        #3;
        rst_n = 1'b1;
        push(0, 0);
        req = 4'b1001;
        step();
        chk("arst_regrant_en", 32'(sound_en), 1);
        req = '0;
        step();
        do_reset();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_arbiter.md
Name: tone_arbiter

Overview:
- Shares the single Sound tone generator between up to N requesters: menu/set confirm beep, auto, free, study and play paths.
- Accepts one note request at a time and latches its octave, note and length.
- Sequences the generator through an enable/over handshake, then enforces a silent gap between notes.
- Round-robin arbitration, with optional preemption by requester 0 (the confirm beep).

Parameters:
N, 4, number of requesters (2..8)
OCT_W, 3, octave field width
NOTE_W, 3, note field width
LEN_W, 3, length field width
GAP_CYCLES, 5000000, silent cycles after each note (50 ms at 100 MHz); 0 = no gap
TIMEOUT, 1000, max cycles in START waiting for sound_over to drop
PREEMPT, 1, 1 = req[0] may abort a note in progress for another requester

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N  level request per requester; held until gnt
req_oct  in  N*OCT_W  octave fields, requester i at slice i
req_note  in  N*NOTE_W  note fields
req_len  in  N*LEN_W  length fields
cancel  in  1  abort the current note (from cancel key Pulse)
sound_over  in  1  generator idle/done flag; high = idle
sound_en  out  1  generator enable
sound_oct  out  OCT_W  latched octave to generator
sound_note  out  NOTE_W  latched note
sound_len  out  LEN_W  latched length
gnt  out  N  one-hot, 1-cycle pulse: fields captured
done  out  N  one-hot, 1-cycle pulse: note finished normally
abort  out  N  one-hot, 1-cycle pulse: note killed (cancel/preempt/timeout)
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values:
  - state=IDLE; all outputs 0; sound_* fields 0.
  - rr pointer = N-1, so req[0] wins first; pre_pend=0; counters 0.
- States: IDLE, START, PLAY, GAP; 2-bit encoding.
- IDLE:
  - If pre_pend and req[0]: winner=0.
  - Otherwise, if any req: winner = first set bit scanning ptr+1, ptr+2, ... modulo N.
  - On a winner: latch its fields into sound_*, pulse gnt[winner], ptr<=winner, clear pre_pend, go START.
  - No req: stay; sound_en=0.
- START:
  - sound_en=1. Wait for sound_over=0 (generator accepted), then go PLAY.
  - Counter increments each cycle. At TIMEOUT cycles without acceptance: pulse abort[winner], go GAP.
- PLAY:
  - sound_en=1. On sound_over=1: sound_en<=0, pulse done[winner], go GAP.
- GAP:
  - sound_en=0. Count GAP_CYCLES cycles, then go IDLE.
  - GAP_CYCLES=0: single-cycle pass to IDLE.
  - Requests are not sampled in GAP; new notes cannot start until IDLE.
- Latency: req asserted in IDLE -> gnt next edge -> sound_en high the same edge as gnt.
- sound_* fields are stable from gnt until the next gnt. Requester fields may change after gnt.
- cancel in START or PLAY:
  - sound_en<=0 next edge, pulse abort[winner], go GAP.
  - done is not pulsed.
  - cancel in IDLE or GAP is ignored.
- Preemption (PREEMPT=1):
  - Applies when req[0] is asserted in START or PLAY while winner!=0.
  - Abort the note as for cancel and set pre_pend=1.
  - req[0] is then served at the next IDLE regardless of ptr.
  - If req[0] drops before IDLE, pre_pend is cleared at arbitration and normal round-robin applies.
  - winner==0 is never preempted.
- Simultaneous cancel and preempt in one cycle: single abort pulse; pre_pend still set.
- Simultaneous sound_over=1 and cancel in PLAY: done wins (note completed); abort not pulsed.
- At most one of gnt/done/abort is high per cycle; each is one-hot or zero.
- Counter widths: $clog2(max(GAP_CYCLES,TIMEOUT)+1). Counters reset to 0 on every state entry.
- Reset mid-note: immediate return to reset values; sound_en drops asynchronously.

Test Plan:
- Single note: req=4'b0010, note=3, oct=4, len=4 -> gnt=0010 next cycle, sound_en=1 until sound_over rises, done=0010 one cycle, busy low after GAP_CYCLES (bench GAP_CYCLES=10) more cycles.
- Round-robin fairness: req=4'b1111 held, generator modelled at 20 cycles/note -> grant order 0,1,2,3,0; no requester granted twice before all others.
- Preemption: requester 2 in PLAY, pulse req[0] -> abort=0100 next edge, sound_en=0, after GAP gnt=0001 even though ptr=2.
- Cancel vs completion: cancel and sound_over rise on the same edge in PLAY -> done pulses, abort stays 0. Cancel alone in START -> abort, no done.
- Timeout: sound_over held 1 forever, TIMEOUT=8 -> sound_en high exactly 8 cycles in START, then abort of winner, return to IDLE.
- Async reset mid-PLAY: drop rst_n between clock edges -> sound_en, busy, gnt/done/abort 0 immediately. After release, req=4'b1001 -> gnt=0001.
